addsub_share_arbiter: RTL and testbench



---
 rtl/addsub_share_arbiter_pkg.sv | 8 +
 rtl/adder_subtractor.sv | 10 +
 rtl/addsub_share_arbiter.sv | 88 ++++++++
 tb/tb_addsub_share_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_share_arbiter_pkg.sv
// addsub_share_arbiter_pkg: shared types and constants for the arbitrated add/sub block
package addsub_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam int ID_W = 1;
  typedef logic [ID_W-1:0] id_t;
endpackage

// File: rtl/adder_subtractor.sv
// adder_subtractor: 4-bit adder, subtracts as in1 + ~in2 + 1 when mode is high
module adder_subtractor (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       mode,
  output logic [3:0] out,
  output logic       carry
);
  assign {carry, out} = {1'b0, in1} + {1'b0, in2 ^ {4{mode}}} + {4'b0, mode};
endmodule

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter: round-robin sharing of one adder_subtractor between two requesters
module addsub_share_arbiter
  import addsub_share_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_in1,
  input  logic [3:0] req0_in2,
  input  logic       req0_mode,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_in1,
  input  logic [3:0] req1_in2,
  input  logic       req1_mode,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_out,
  output logic       rsp_carry,
  output logic       rsp_ovf,
  output logic       busy
);
  state_t     state;
  id_t        ptr;
  id_t        id;
  id_t        gnt_id;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       m;
  logic       c;
  logic       gnt;
  adder_subtractor u_alu (
    .in1  (a),
    .in2  (b),
    .mode (m),
    .out  (sum),
    .carry(c)
  );
  always_comb begin
    gnt    = (state == IDLE) && (req0_valid || req1_valid);
    gnt_id = (req0_valid && req1_valid) ? ptr : id_t'(req1_valid);
  end
  assign req0_ready = gnt && (gnt_id == id_t'(0));
  assign req1_ready = gnt && (gnt_id == id_t'(1));
  assign rsp0_valid = (state == RESP) && (id == id_t'(0));
  assign rsp1_valid = (state == RESP) && (id == id_t'(1));
  assign busy       = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= id_t'(RR_INIT);
      id        <= '0;
      a         <= '0;
      b         <= '0;
      m         <= MODE_ADD;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (gnt) begin
          id    <= gnt_id;
          a     <= gnt_id[0] ? req1_in1 : req0_in1;
          b     <= gnt_id[0] ? req1_in2 : req0_in2;
          m     <= gnt_id[0] ? req1_mode : req0_mode;
          state <= EXEC;
        end
        EXEC: begin
          rsp_out   <= sum;
          rsp_carry <= c;
          rsp_ovf   <= ((m == MODE_SUB) ? (a[3] != b[3]) : (a[3] == b[3])) && (sum[3] != a[3]);
          state     <= RESP;
        end
        RESP: if (id[0] ? rsp1_ready : rsp0_ready) begin
          ptr   <= ~id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// tb_addsub_share_arbiter: vector table, sequences and randomized ops against an arithmetic model
module tb_addsub_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic       req0_mode = 1'b0, req1_mode = 1'b0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [3:0] rsp_out;
  logic       rsp_carry, rsp_ovf, busy;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    bit         p;
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] o;
    logic       c;
    logic       v;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  addsub_share_arbiter #(.RR_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_in1  (req0_in1),
    .req0_in2  (req0_in2),
    .req0_mode (req0_mode),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_in1  (req1_in1),
    .req1_in2  (req1_in2),
    .req1_mode (req1_mode),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
    int sa = (a > 7) ? int'(a) - 16 : int'(a);
    int sb = (b > 7) ? int'(b) - 16 : int'(b);
    int r  = m ? sa - sb : sa + sb;
    int u  = m ? int'(a) - int'(b) : int'(a) + int'(b);
    logic [3:0] o = 4'(u & 15);
    logic c = m ? (a >= b) : (u > 15);
    logic v = (r > 7) || (r < -8);
    return {v, c, o};
  endfunction
  task automatic set_req(input bit p, input logic v, input logic [3:0] a, input logic [3:0] b, input logic m);
    if (p) begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_mode = m;
    end else begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_mode = m;
    end
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp_out"}, rsp_out, 0);
    chk({tag, "_rsp_carry"}, rsp_carry, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic do_op(input bit p, input logic [3:0] a, input logic [3:0] b, input logic m,
                       input logic [3:0] eo, input logic ec, input logic ev);
    @(negedge clk);
    set_req(p, 1'b1, a, b, m);
    #1;
    chk("grant_ready", p ? req1_ready : req0_ready, 1);
    chk("grant_other_ready", p ? req0_ready : req1_ready, 0);
    @(negedge clk);
    set_req(p, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
    chk("exec_rsp_valid", rsp0_valid | rsp1_valid, 0);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    chk("rsp_valid", p ? rsp1_valid : rsp0_valid, 1);
    chk("rsp_other_valid", p ? rsp0_valid : rsp1_valid, 0);
    chk("rsp_out", rsp_out, eo);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_ovf", rsp_ovf, ev);
    @(negedge clk);
    chk("done_busy", busy, 0);
  endtask
  initial begin
    vecs[0] = '{0, 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[1] = '{1, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[2] = '{1, 4'd9, 4'd2, 1'b1, 4'd7, 1'b1, 1'b1};
    vecs[3] = '{1, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[4] = '{0, 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[5] = '{0, 4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1};
    vecs[6] = '{0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[7] = '{1, 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0};
    reset_dut();
    #1;
    check_idle_outputs("reset");
    foreach (vecs[i])
      do_op(vecs[i].p, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].o, vecs[i].c, vecs[i].v);
    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      bit p = 1'($urandom);
      logic [3:0] a = 4'($urandom), b = 4'($urandom);
      logic m = 1'($urandom);
      logic [5:0] e = model(a, b, m);
      do_op(p, a, b, m, e[3:0], e[4], e[5]);
    end
    // Round robin with both requesters always valid
    begin
      int gcyc[$];
      int gid[$];
      reset_dut();
      set_req(0, 1'b1, 4'd1, 4'd2, 1'b0);
      set_req(1, 1'b1, 4'd6, 4'd4, 1'b1);
      for (int cyc = 0; cyc < 40 && gid.size() < 4; cyc++) begin
        #1;
        if (req0_ready) begin gcyc.push_back(cyc); gid.push_back(0); end
        if (req1_ready) begin gcyc.push_back(cyc); gid.push_back(1); end
        if (rsp0_valid) chk("rr_rsp0_out", rsp_out, 3);
        if (rsp1_valid) chk("rr_rsp1_out", rsp_out, 2);
        @(negedge clk);
      end
      chk("rr_grant_count", gid.size(), 4);
      for (int i = 0; i < gid.size(); i++) chk("rr_grant_id", gid[i], i % 2);
      for (int i = 1; i < gcyc.size(); i++) chk("rr_grant_gap", gcyc[i] - gcyc[i-1], 3);
      set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
      set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rr_drain_busy", busy, 0);
    end
    // Response backpressure on requester 0 while requester 1 waits
    reset_dut();
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 4'd5, 4'd3, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    set_req(1, 1'b1, 4'd3, 4'd5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp_out", rsp_out, 8);
      chk("bp_req1_ready", req1_ready, 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req1_ready", req1_ready, 1);
    chk("bp_release_rsp0_valid", rsp0_valid, 0);
    @(negedge clk);
    set_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("bp_rsp1_valid", rsp1_valid, 1);
    chk("bp_rsp1_out", rsp_out, 14);
    chk("bp_rsp1_carry", rsp_carry, 0);
    @(negedge clk);
    // Reset during EXEC discards the in-flight operation
    set_req(0, 1'b1, 4'd5, 4'd3, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("rst_exec_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_exec");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_exec_no_rsp0", rsp0_valid, 0);
      chk("rst_exec_idle", busy, 0);
    end
    do_op(1, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
